// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: function codes and FSM states.
// Code width is fixed here; the top widens or narrows it to CTRL_WIDTH.
package alu_pkg;

  localparam int CODE_W = 4;

  localparam logic [CODE_W-1:0] OP_NOP = 4'b0000;
  localparam logic [CODE_W-1:0] OP_MUL = 4'b0001;
  localparam logic [CODE_W-1:0] OP_DIV = 4'b0010;
  localparam logic [CODE_W-1:0] OP_ROR = 4'b1000;
  localparam logic [CODE_W-1:0] OP_ROL = 4'b1001;
  localparam logic [CODE_W-1:0] OP_SLL = 4'b1010;
  localparam logic [CODE_W-1:0] OP_SLR = 4'b1011;
  localparam logic [CODE_W-1:0] OP_OR  = 4'b1100;
  localparam logic [CODE_W-1:0] OP_AND = 4'b1101;
  localparam logic [CODE_W-1:0] OP_SUB = 4'b1110;
  localparam logic [CODE_W-1:0] OP_ADD = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL_RUN,
    S_DIV_RUN,
    S_DONE
  } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per clock.
// o_hi/o_lo expose the post-step value so the caller can capture the final step.
module alu_muldiv_iter #(
  parameter int W  = 16,
  parameter int CW = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_div,
  input  logic         i_step,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_last,
  output logic [W-1:0] o_hi,
  output logic [W-1:0] o_lo
);

  logic          r_div;
  logic [W-1:0]  r_m;
  logic [W-1:0]  r_hi;
  logic [W-1:0]  r_lo;
  logic [CW-1:0] r_cnt;

  logic [W:0]    w_sum;
  logic [W:0]    w_sh;
  logic [W:0]    w_dif;
  logic [W-1:0]  w_hi;
  logic [W-1:0]  w_lo;

  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
  assign w_sh  = {r_hi, r_lo[W-1]};
  assign w_dif = w_sh - {1'b0, r_m};

  always_comb begin
    w_hi = w_sum[W:1];
    w_lo = {w_sum[0], r_lo[W-1:1]};
    if (r_div) begin
      // Top bit of the difference set means the trial subtract underflowed
      if (!w_dif[W]) begin
        w_hi = w_dif[W-1:0];
        w_lo = {r_lo[W-2:0], 1'b1};
      end else begin
        w_hi = w_sh[W-1:0];
        w_lo = {r_lo[W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= 1'b0;
      r_m   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_div <= i_div;
      r_m   <= i_b;
      r_hi  <= '0;
      r_lo  <= i_a;
      r_cnt <= CW'(W);
    end else if (i_step) begin
      r_hi  <= w_hi;
      r_lo  <= w_lo;
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_last = (r_cnt == CW'(1));
  assign o_hi   = w_hi;
  assign o_lo   = w_lo;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, iterative MUL/DIV,
// start/busy/done handshake with registered R/S/exception.
module alu_mc
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CTRL_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [CTRL_WIDTH-1:0] ALU_Ctrl,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] R,
  output logic [DATA_WIDTH-1:0] S,
  output logic                  ALU_Exception
);

  localparam int W         = DATA_WIDTH;
  localparam int CNT_WIDTH = $clog2(DATA_WIDTH + 1);
  localparam logic [W-1:0] LP_W = W'(W);

  state_t       r_state;
  logic         r_busy;
  logic         r_done;
  logic [W-1:0] r_R;
  logic [W-1:0] r_S;
  logic         r_exc;

  logic         w_accept;
  logic         w_is_mul;
  logic         w_is_div;
  logic         w_b_zero;
  logic         w_load;
  logic         w_step;
  logic         w_last;
  logic [W-1:0] w_hi;
  logic [W-1:0] w_lo;

  logic [W-1:0] w_sum;
  logic [W-1:0] w_dif;
  logic [W-1:0] w_rm;
  logic         w_big;
  logic [W-1:0] w_r;
  logic [W-1:0] w_s;
  logic         w_x;

  assign w_accept = start &&
                    (r_state == S_IDLE || r_state == S_DONE);
  assign w_is_mul = (ALU_Ctrl == CTRL_WIDTH'(OP_MUL));
  assign w_is_div = (ALU_Ctrl == CTRL_WIDTH'(OP_DIV));
  assign w_b_zero = (B == '0);
  assign w_load   = w_accept &&
                    (w_is_mul || (w_is_div && !w_b_zero));
  assign w_step   = (r_state == S_MUL_RUN) ||
                    (r_state == S_DIV_RUN);

  alu_muldiv_iter #(
    .W  (W),
    .CW (CNT_WIDTH)
  ) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_div  (w_is_div),
    .i_step (w_step),
    .i_a    (A),
    .i_b    (B),
    .o_last (w_last),
    .o_hi   (w_hi),
    .o_lo   (w_lo)
  );

  assign w_sum = A + B;
  assign w_dif = A - B;
  assign w_rm  = B % LP_W;
  assign w_big = (B >= LP_W);

  always_comb begin
    w_r = '0;
    w_s = '0;
    w_x = 1'b0;
    unique case (1'b1)
      (ALU_Ctrl == CTRL_WIDTH'(OP_ADD)): begin
        w_r = w_sum;
        w_x = (A[W-1] == B[W-1]) &&
              (w_sum[W-1] != A[W-1]);
      end
      (ALU_Ctrl == CTRL_WIDTH'(OP_SUB)): begin
        w_r = w_dif;
        w_x = (A[W-1] != B[W-1]) &&
              (w_dif[W-1] != A[W-1]);
      end
      (ALU_Ctrl == CTRL_WIDTH'(OP_AND)): w_r = A & B;
      (ALU_Ctrl == CTRL_WIDTH'(OP_OR)):  w_r = A | B;
      (ALU_Ctrl == CTRL_WIDTH'(OP_SLL)): w_r = w_big ? '0 : A << B;
      (ALU_Ctrl == CTRL_WIDTH'(OP_SLR)): w_r = w_big ? '0 : A >> B;
      (ALU_Ctrl == CTRL_WIDTH'(OP_ROL)):
        w_r = (A << w_rm) | (A >> (LP_W - w_rm));
      (ALU_Ctrl == CTRL_WIDTH'(OP_ROR)):
        w_r = (A >> w_rm) | (A << (LP_W - w_rm));
      // Only reached on the single-cycle path when B is zero
      w_is_div: begin
        w_r = '1;
        w_s = A;
        w_x = 1'b1;
      end
      w_is_mul: w_r = '0;
      (ALU_Ctrl == CTRL_WIDTH'(OP_NOP)): w_r = '0;
      default: w_x = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_R     <= '0;
      r_S     <= '0;
      r_exc   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (w_is_mul) begin
              r_state <= S_MUL_RUN;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end else if (w_is_div && !w_b_zero) begin
              r_state <= S_DIV_RUN;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_R     <= w_r;
              r_S     <= w_s;
              r_exc   <= w_x;
            end
          end else begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end
        end
        S_MUL_RUN, S_DIV_RUN: begin
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_R     <= w_lo;
            r_S     <= w_hi;
            r_exc   <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign R             = r_R;
  assign S             = r_S;
  assign ALU_Exception = r_exc;

endmodule

// File: tb/tb_alu_mc.sv
// Directed vector bench for alu_mc (W=16): table of ops plus
// hand sequences for ignored start, back-to-back and reset abort.
module tb_alu_mc;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic [3:0]  ALU_Ctrl;
  logic        busy;
  logic        done;
  logic [15:0] R;
  logic [15:0] S;
  logic        exc;

  int checks   = 0;
  int failures = 0;

  alu_mc #(
    .DATA_WIDTH (16),
    .CTRL_WIDTH (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .A             (A),
    .B             (B),
    .ALU_Ctrl      (ALU_Ctrl),
    .busy          (busy),
    .done          (done),
    .R             (R),
    .S             (S),
    .ALU_Exception (exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [3:0]  c;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic [15:0] s;
    logic        x;
    int          lat;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Called just after a falling edge; returns at the falling edge
  // where done is first seen (lat = rising edges since acceptance).
  task automatic run_op(input logic [3:0] c,
                        input logic [15:0] a,
                        input logic [15:0] b,
                        output int lat,
                        output int nbusy);
    start    = 1'b1;
    ALU_Ctrl = c;
    A        = a;
    B        = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    A     = ~a;
    B     = ~b;
    lat   = 0;
    nbusy = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) nbusy++;
      if (done) break;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int nb;
    int ndone;

    tv.push_back('{"add_ovf", 4'hF, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 1'b1, 1});
    tv.push_back('{"add_small", 4'hF, 16'h0003, 16'h0004, 16'h0007, 16'h0000, 1'b0, 1});
    tv.push_back('{"add_wrap", 4'hF, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1});
    tv.push_back('{"sub_small", 4'hE, 16'h0005, 16'h0003, 16'h0002, 16'h0000, 1'b0, 1});
    tv.push_back('{"sub_ovf", 4'hE, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 1'b1, 1});
    tv.push_back('{"and", 4'hD, 16'hF0F0, 16'h3C3C, 16'h3030, 16'h0000, 1'b0, 1});
    tv.push_back('{"or", 4'hC, 16'hF0F0, 16'h0F00, 16'hFFF0, 16'h0000, 1'b0, 1});
    tv.push_back('{"sll_16", 4'hA, 16'h0001, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1});
    tv.push_back('{"sll_4", 4'hA, 16'h0003, 16'h0004, 16'h0030, 16'h0000, 1'b0, 1});
    tv.push_back('{"slr_15", 4'hB, 16'h8000, 16'h000F, 16'h0001, 16'h0000, 1'b0, 1});
    tv.push_back('{"slr_20", 4'hB, 16'hFFFF, 16'h0014, 16'h0000, 16'h0000, 1'b0, 1});
    tv.push_back('{"rol_17", 4'h9, 16'h8001, 16'h0011, 16'h0003, 16'h0000, 1'b0, 1});
    tv.push_back('{"rol_16", 4'h9, 16'h1234, 16'h0010, 16'h1234, 16'h0000, 1'b0, 1});
    tv.push_back('{"ror_1", 4'h8, 16'h0001, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1});
    tv.push_back('{"ror_4", 4'h8, 16'h1234, 16'h0004, 16'h4123, 16'h0000, 1'b0, 1});
    tv.push_back('{"mul_max", 4'h1, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 17});
    tv.push_back('{"nop", 4'h0, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 1'b0, 1});
    tv.push_back('{"mul_sm", 4'h1, 16'h1234, 16'h0010, 16'h2340, 16'h0001, 1'b0, 17});
    tv.push_back('{"code3", 4'h3, 16'h0005, 16'h0006, 16'h0000, 16'h0000, 1'b1, 1});
    tv.push_back('{"div_100_7", 4'h2, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 17});
    tv.push_back('{"div_by0", 4'h2, 16'h0005, 16'h0000, 16'hFFFF, 16'h0005, 1'b1, 1});
    tv.push_back('{"div_ffff_1", 4'h2, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 17});
    tv.push_back('{"div_3_5", 4'h2, 16'h0003, 16'h0005, 16'h0000, 16'h0003, 1'b0, 17});
    tv.push_back('{"code7", 4'h7, 16'hAAAA, 16'h5555, 16'h0000, 16'h0000, 1'b1, 1});

    rst_n    = 1'b0;
    start    = 1'b0;
    A        = '0;
    B        = '0;
    ALU_Ctrl = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_R", 32'(R), 32'd0);
    chk("rst_S", 32'(S), 32'd0);
    chk("rst_exc", 32'(exc), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tv[i]) begin
      run_op(tv[i].c, tv[i].a, tv[i].b, lat, nb);
      chk({tv[i].nm, "_lat"}, 32'(lat), 32'(tv[i].lat));
      chk({tv[i].nm, "_R"}, 32'(R), 32'(tv[i].r));
      chk({tv[i].nm, "_S"}, 32'(S), 32'(tv[i].s));
      chk({tv[i].nm, "_exc"}, 32'(exc), 32'(tv[i].x));
    end

    // MUL from IDLE: busy count, then done drops and R holds
    @(negedge clk);
    @(negedge clk);
    chk("idle_done", 32'(done), 32'd0);
    run_op(4'h1, 16'hFFFF, 16'hFFFF, lat, nb);
    chk("mul_busy_cnt", 32'(nb), 32'd16);
    chk("mul_lat", 32'(lat), 32'd17);
    chk("mul_busy_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_pulse_end", 32'(done), 32'd0);
    chk("R_held", 32'(R), 32'h0001);
    chk("S_held", 32'(S), 32'hFFFE);

    // start pulsed mid-MUL with new operands must be ignored
    start    = 1'b1;
    ALU_Ctrl = 4'h1;
    A        = 16'h0003;
    B        = 16'h0005;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      start = (lat >= 3 && lat < 6);
      if (lat == 3) begin
        ALU_Ctrl = 4'hF;
        A        = 16'hFFFF;
        B        = 16'hFFFF;
      end
      if (done) break;
    end
    chk("ign_lat", 32'(lat), 32'd17);
    chk("ign_R", 32'(R), 32'h000F);
    chk("ign_S", 32'(S), 32'h0000);
    chk("ign_exc", 32'(exc), 32'd0);
    start = 1'b0;

    // back-to-back single-cycle ops accepted straight from DONE
    run_op(4'hF, 16'h0003, 16'h0004, lat, nb);
    chk("b2b1_R", 32'(R), 32'h0007);
    run_op(4'hF, 16'h0010, 16'h0020, lat, nb);
    chk("b2b2_lat", 32'(lat), 32'd1);
    chk("b2b2_R", 32'(R), 32'h0030);
    chk("b2b2_done", 32'(done), 32'd1);

    // reset asserted during DIV iteration 8
    start    = 1'b1;
    ALU_Ctrl = 4'h2;
    A        = 16'h0064;
    B        = 16'h0007;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("div_mid_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_R", 32'(R), 32'd0);
    chk("abort_S", 32'(S), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    nb    = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) ndone++;
      if (busy) nb++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    chk("abort_no_busy", 32'(nb), 32'd0);

    // undefined code after a nonzero result clears R/S and excepts
    run_op(4'hF, 16'h0001, 16'h0001, lat, nb);
    chk("pre3_R", 32'(R), 32'h0002);
    run_op(4'h3, 16'h1111, 16'h2222, lat, nb);
    chk("c3_lat", 32'(lat), 32'd1);
    chk("c3_R", 32'(R), 32'd0);
    chk("c3_S", 32'(S), 32'd0);
    chk("c3_exc", 32'(exc), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
